// File: rtl/uart_xcvr_pkg.sv
// Shared definitions for the UART transceiver: FSM state encoding,
// oversampling constants and the parity helper used by both directions.
package uart_xcvr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Oversampling: 16 ticks per bit, start bit checked at its middle tick.
  localparam int TICKS_PER_BIT = 16;
  localparam int MID_TICK      = 7;

  // Wide enough to count the longest stop period (2 stop bits = 32 ticks).
  localparam int SCNT_W = 5;

  // Parity of an already-masked data word; odd selects odd parity.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_xcvr_if.sv
// Host-side bus of the UART transceiver: TX push, RX pop and error flags.
interface uart_xcvr_if;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       tx_full;
  logic       tx_busy;
  logic       rd_uart;
  logic [7:0] r_data;
  logic       rx_empty;
  logic       err_clr;
  logic       rx_frame_err;
  logic       rx_parity_err;
  logic       rx_overrun;

  modport master (
    output wr_uart, w_data, rd_uart, err_clr,
    input  tx_full, tx_busy, r_data, rx_empty,
    input  rx_frame_err, rx_parity_err, rx_overrun
  );

  modport slave (
    input  wr_uart, w_data, rd_uart, err_clr,
    output tx_full, tx_busy, r_data, rx_empty,
    output rx_frame_err, rx_parity_err, rx_overrun
  );
endinterface

// File: rtl/fifo.sv
// Synchronous FIFO with one extra pointer bit to tell full from empty.
// A write while full is accepted only when a read frees a slot that cycle;
// a read while empty is ignored.
module fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [DATA_W-1:0] w_data,
  output logic              empty,
  output logic              full,
  output logic [DATA_W-1:0] r_data
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W:0]   wptr_q, rptr_q;
  logic              wr_en, rd_en;

  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                  (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
  assign rd_en  = rd && !empty;
  assign wr_en  = wr && (!full || rd);
  assign r_data = mem[rptr_q[ADDR_W-1:0]];

  // Advance read/write pointers on accepted operations.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (rd_en) rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (reset && wr_en) mem[wptr_q[ADDR_W-1:0]] <= w_data;
  end
endmodule

// File: rtl/uart_rx_p.sv
// UART receiver: 2-flop synchroniser, start-edge detection with glitch
// rejection, mid-bit sampling, and per-frame error indications.
module uart_rx_p
  import uart_xcvr_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       rx,
  output logic       push,
  output logic [7:0] dout,
  output logic       frame_err,
  output logic       parity_err
);
  logic [1:0]        sync_q;
  logic              rx_s, rx_prev_q, armed_q, fall;
  uart_state_e       state_q, state_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [2:0]        nbit_q, nbit_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              par_q, par_d;

  assign rx_s = sync_q[1];
  assign fall = armed_q && rx_prev_q && !rx_s;
  assign dout = shreg_q >> (8 - DBIT);

  // Synchronise rx and arm edge detection once the line has been seen idle-high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q    <= '0;
      rx_prev_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx};
      rx_prev_q <= rx_s;
      if (rx_s && rx_prev_q) armed_q <= 1'b1;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      scnt_q  <= '0;
      nbit_q  <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      nbit_q  <= nbit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
    end
  end

  // Next-state logic; the frame is handed out in the cycle the stop bit is sampled.
  always_comb begin
    state_d    = state_q;
    scnt_d     = scnt_q;
    nbit_d     = nbit_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    push       = 1'b0;
    frame_err  = 1'b0;
    parity_err = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_START;
          scnt_d  = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (scnt_q == SCNT_W'(MID_TICK)) begin
            if (rx_s) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DATA;
              scnt_d  = '0;
              nbit_d  = '0;
              shreg_d = '0;
            end
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (scnt_q == SCNT_W'(TICKS_PER_BIT - 1)) begin
            scnt_d  = '0;
            shreg_d = {rx_s, shreg_q[7:1]};
            if (nbit_q == 3'(DBIT - 1)) state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            else                        nbit_d  = nbit_q + 1'b1;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          if (scnt_q == SCNT_W'(TICKS_PER_BIT - 1)) begin
            scnt_d  = '0;
            par_d   = rx_s;
            state_d = ST_STOP;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (scnt_q == SCNT_W'(TICKS_PER_BIT - 1)) begin
            push       = 1'b1;
            frame_err  = !rx_s;
            parity_err = (PARITY_EN != 0) && (par_q != parity_bit(dout, 1'(PARITY_ODD)));
            state_d    = ST_IDLE;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: rtl/uart_xcvr.sv
// UART transceiver top: baud tick generator, TX FIFO and transmitter FSM,
// receiver with RX FIFO, and sticky error flags.
module uart_xcvr
  import uart_xcvr_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int SB_TICK    = 16,
  parameter int DVSR_BIT   = 11,
  parameter int FIFO_W     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DVSR_BIT-1:0] dvsr,
  input  logic                rx,
  output logic                tx,
  uart_xcvr_if.slave          bus
);
  localparam logic [7:0] DATA_MASK = 8'((16'd1 << DBIT) - 16'd1);

  logic [DVSR_BIT-1:0] baud_cnt_q, dvsr_q;
  logic                tick;

  logic                tx_empty, tx_pop;
  logic [7:0]          tx_head;
  uart_state_e         tx_state_q, tx_state_d;
  logic [SCNT_W-1:0]   tx_scnt_q, tx_scnt_d;
  logic [2:0]          tx_nbit_q, tx_nbit_d;
  logic [7:0]          tx_shreg_q, tx_shreg_d;
  logic                tx_par_q, tx_par_d;
  logic                tx_loaded_q, tx_loaded_d;
  logic                tx_q, tx_d;

  logic                rx_push, rx_full, rx_frame_evt, rx_parity_evt;
  logic [7:0]          rx_data;
  logic                frame_err_q, parity_err_q, overrun_q;

  assign tick = (dvsr_q >= DVSR_BIT'(2)) && (baud_cnt_q == dvsr_q - 1'b1);

  // Baud counter; the divisor is re-captured only at a wrap or while stalled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      baud_cnt_q <= '0;
      dvsr_q     <= '0;
    end else if (dvsr_q < DVSR_BIT'(2) || tick) begin
      baud_cnt_q <= '0;
      dvsr_q     <= dvsr;
    end else begin
      baud_cnt_q <= baud_cnt_q + 1'b1;
    end
  end

  fifo #(.DATA_W(8), .ADDR_W(FIFO_W)) u_tx_fifo (
    .clk(clk), .reset(reset), .rd(tx_pop), .wr(bus.wr_uart), .w_data(bus.w_data),
    .empty(tx_empty), .full(bus.tx_full), .r_data(tx_head)
  );

  // Transmitter state register; tx is registered so the line never glitches.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state_q  <= ST_IDLE;
      tx_scnt_q   <= '0;
      tx_nbit_q   <= '0;
      tx_shreg_q  <= '0;
      tx_par_q    <= 1'b0;
      tx_loaded_q <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_scnt_q   <= tx_scnt_d;
      tx_nbit_q   <= tx_nbit_d;
      tx_shreg_q  <= tx_shreg_d;
      tx_par_q    <= tx_par_d;
      tx_loaded_q <= tx_loaded_d;
      tx_q        <= tx_d;
    end
  end

  // Transmitter next-state; a word is popped on load and the frame starts at the next tick.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_scnt_d   = tx_scnt_q;
    tx_nbit_d   = tx_nbit_q;
    tx_shreg_d  = tx_shreg_q;
    tx_par_d    = tx_par_q;
    tx_loaded_d = tx_loaded_q;
    tx_pop      = 1'b0;
    unique case (tx_state_q)
      ST_IDLE: begin
        if (tx_loaded_q) begin
          if (tick) begin
            tx_state_d  = ST_START;
            tx_scnt_d   = '0;
            tx_loaded_d = 1'b0;
          end
        end else if (!tx_empty) begin
          tx_pop      = 1'b1;
          tx_shreg_d  = tx_head & DATA_MASK;
          tx_par_d    = parity_bit(tx_head & DATA_MASK, 1'(PARITY_ODD));
          tx_loaded_d = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          if (tx_scnt_q == SCNT_W'(TICKS_PER_BIT - 1)) begin
            tx_state_d = ST_DATA;
            tx_scnt_d  = '0;
            tx_nbit_d  = '0;
          end else begin
            tx_scnt_d = tx_scnt_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (tx_scnt_q == SCNT_W'(TICKS_PER_BIT - 1)) begin
            tx_scnt_d  = '0;
            tx_shreg_d = tx_shreg_q >> 1;
            if (tx_nbit_q == 3'(DBIT - 1)) tx_state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            else                           tx_nbit_d  = tx_nbit_q + 1'b1;
          end else begin
            tx_scnt_d = tx_scnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          if (tx_scnt_q == SCNT_W'(TICKS_PER_BIT - 1)) begin
            tx_scnt_d  = '0;
            tx_state_d = ST_STOP;
          end else begin
            tx_scnt_d = tx_scnt_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (tx_scnt_q == SCNT_W'(SB_TICK - 1)) begin
            tx_scnt_d = '0;
            if (!tx_empty) begin
              tx_pop     = 1'b1;
              tx_shreg_d = tx_head & DATA_MASK;
              tx_par_d   = parity_bit(tx_head & DATA_MASK, 1'(PARITY_ODD));
              tx_state_d = ST_START;
            end else begin
              tx_state_d = ST_IDLE;
            end
          end else begin
            tx_scnt_d = tx_scnt_q + 1'b1;
          end
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
    unique case (tx_state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = tx_shreg_d[0];
      ST_PARITY: tx_d = tx_par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx          = tx_q;
  assign bus.tx_busy = (tx_state_q != ST_IDLE) || tx_loaded_q;

  uart_rx_p #(.DBIT(DBIT), .PARITY_EN(PARITY_EN), .PARITY_ODD(PARITY_ODD)) u_rx (
    .clk(clk), .reset(reset), .tick(tick), .rx(rx), .push(rx_push), .dout(rx_data),
    .frame_err(rx_frame_evt), .parity_err(rx_parity_evt)
  );

  fifo #(.DATA_W(8), .ADDR_W(FIFO_W)) u_rx_fifo (
    .clk(clk), .reset(reset), .rd(bus.rd_uart), .wr(rx_push), .w_data(rx_data),
    .empty(bus.rx_empty), .full(rx_full), .r_data(bus.r_data)
  );

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_err_q  <= (frame_err_q && !bus.err_clr) || (rx_push && rx_frame_evt);
      parity_err_q <= (parity_err_q && !bus.err_clr) || (rx_push && rx_parity_evt);
      overrun_q    <= (overrun_q && !bus.err_clr) || (rx_push && rx_full && !bus.rd_uart);
    end
  end

  assign bus.rx_frame_err  = frame_err_q;
  assign bus.rx_parity_err = parity_err_q;
  assign bus.rx_overrun    = overrun_q;
endmodule

// File: tb/tb_uart_xcvr.sv
// Directed bench for uart_xcvr: instance A is 8N1 with a 4-deep FIFO,
// instance B is 8O1 with a 16-deep FIFO. Bits are 16 ticks * dvsr 4 = 64 clk.
module tb_uart_xcvr;
  import uart_xcvr_pkg::*;

  localparam int BIT_CLKS = 64;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic [10:0] dvsr     = 11'd4;
  logic        loop_a   = 1'b0;
  logic        loop_b   = 1'b0;
  logic        rx_drv_a = 1'b1;
  logic        rx_drv_b = 1'b1;
  logic        tx_a, tx_b, rx_a, rx_b;
  int          checks   = 0;
  int          errors   = 0;
  int          width;
  logic [7:0]  ovr_bytes [5];

  uart_xcvr_if if_a ();
  uart_xcvr_if if_b ();

  assign rx_a = loop_a ? tx_a : rx_drv_a;
  assign rx_b = loop_b ? tx_b : rx_drv_b;

  uart_xcvr #(.DBIT(8), .PARITY_EN(0), .PARITY_ODD(0), .SB_TICK(16), .DVSR_BIT(11), .FIFO_W(2)) dut_a (
    .clk(clk), .reset(reset), .dvsr(dvsr), .rx(rx_a), .tx(tx_a), .bus(if_a)
  );

  uart_xcvr #(.DBIT(8), .PARITY_EN(1), .PARITY_ODD(1), .SB_TICK(16), .DVSR_BIT(11), .FIFO_W(4)) dut_b (
    .clk(clk), .reset(reset), .dvsr(dvsr), .rx(rx_b), .tx(tx_b), .bus(if_b)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a serial frame LSB first onto the selected rx line, one bit per 64 clk.
  task automatic applyStimulus(input int sel, input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (sel == 0) rx_drv_a = bits[i];
      else          rx_drv_b = bits[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx_drv_a = 1'b1;
    rx_drv_b = 1'b1;
  endtask

  task automatic writeTx(input int sel, input logic [7:0] b);
    @(negedge clk);
    if (sel == 0) begin if_a.w_data = b; if_a.wr_uart = 1'b1; end
    else          begin if_b.w_data = b; if_b.wr_uart = 1'b1; end
    @(negedge clk);
    if_a.wr_uart = 1'b0;
    if_b.wr_uart = 1'b0;
  endtask

  task automatic popRx(input int sel);
    @(negedge clk);
    if (sel == 0) if_a.rd_uart = 1'b1;
    else          if_b.rd_uart = 1'b1;
    @(negedge clk);
    if_a.rd_uart = 1'b0;
    if_b.rd_uart = 1'b0;
  endtask

  task automatic clearErr(input int sel);
    @(negedge clk);
    if (sel == 0) if_a.err_clr = 1'b1;
    else          if_b.err_clr = 1'b1;
    @(negedge clk);
    if_a.err_clr = 1'b0;
    if_b.err_clr = 1'b0;
  endtask

  task automatic waitRx(input int sel, input int budget);
    for (int n = 0; n < budget; n++) begin
      if (((sel == 0) ? if_a.rx_empty : if_b.rx_empty) == 1'b0) break;
      @(negedge clk);
    end
  endtask

  task automatic waitTxFall(input int sel, input int budget);
    for (int n = 0; n < budget; n++) begin
      if (((sel == 0) ? tx_a : tx_b) == 1'b0) break;
      @(negedge clk);
    end
  endtask

  task automatic waitTxIdle(input int sel, input int budget);
    for (int n = 0; n < budget; n++) begin
      if (((sel == 0) ? if_a.tx_busy : if_b.tx_busy) == 1'b0) break;
      @(negedge clk);
    end
  endtask

  // Main directed sequence.
  initial begin
    if_a.wr_uart = 1'b0; if_a.w_data = '0; if_a.rd_uart = 1'b0; if_a.err_clr = 1'b0;
    if_b.wr_uart = 1'b0; if_b.w_data = '0; if_b.rd_uart = 1'b0; if_b.err_clr = 1'b0;
    ovr_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    repeat (4) @(negedge clk);
    checkOutput("rst_tx", tx_a, 1'b1);
    checkOutput("rst_busy", if_a.tx_busy, 1'b0);
    checkOutput("rst_full", if_a.tx_full, 1'b0);
    checkOutput("rst_empty", if_a.rx_empty, 1'b1);
    checkOutput("rst_ferr", if_a.rx_frame_err, 1'b0);
    checkOutput("rst_perr", if_a.rx_parity_err, 1'b0);
    checkOutput("rst_ovr", if_a.rx_overrun, 1'b0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Loopback of two bytes on instance A.
    loop_a = 1'b1;
    writeTx(0, 8'hA5);
    writeTx(0, 8'h3C);
    waitTxFall(0, 200);
    checkOutput("lb_start_seen", tx_a, 1'b0);
    width = 0;
    while (tx_a == 1'b0 && width < 200) begin
      width++;
      @(negedge clk);
    end
    checkOutput("lb_bit_width", width, 64);
    checkOutput("lb_busy", if_a.tx_busy, 1'b1);
    waitRx(0, 2000);
    checkOutput("lb_first_ready", if_a.rx_empty, 1'b0);
    checkOutput("lb_first_data", if_a.r_data, 8'hA5);
    popRx(0);
    checkOutput("lb_empty_between", if_a.rx_empty, 1'b1);
    waitRx(0, 2000);
    checkOutput("lb_second_data", if_a.r_data, 8'h3C);
    popRx(0);
    waitTxIdle(0, 500);
    checkOutput("lb_idle_busy", if_a.tx_busy, 1'b0);
    checkOutput("lb_idle_tx", tx_a, 1'b1);
    checkOutput("lb_no_ferr", if_a.rx_frame_err, 1'b0);
    checkOutput("lb_drained", if_a.rx_empty, 1'b1);
    loop_a = 1'b0;
    repeat (10) @(negedge clk);

    // Frame error: 0x55 with the stop bit held low; byte is still stored.
    applyStimulus(0, {1'b0, 8'h55, 1'b0}, 10);
    repeat (4) @(negedge clk);
    checkOutput("ferr_pushed", if_a.rx_empty, 1'b0);
    checkOutput("ferr_data", if_a.r_data, 8'h55);
    checkOutput("ferr_flag", if_a.rx_frame_err, 1'b1);
    popRx(0);
    clearErr(0);
    checkOutput("ferr_cleared", if_a.rx_frame_err, 1'b0);

    // Glitch: 3-tick low pulse (12 clk) must not start a frame.
    repeat (20) @(negedge clk);
    rx_drv_a = 1'b0;
    repeat (12) @(negedge clk);
    rx_drv_a = 1'b1;
    repeat (200) @(negedge clk);
    checkOutput("glitch_no_push", if_a.rx_empty, 1'b1);
    checkOutput("glitch_idle", 32'(dut_a.u_rx.state_q), 32'(ST_IDLE));
    applyStimulus(0, {1'b1, 8'h96, 1'b0}, 10);
    repeat (4) @(negedge clk);
    checkOutput("post_glitch_data", if_a.r_data, 8'h96);
    popRx(0);

    // Overrun: five frames into a four-entry FIFO.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, {1'b1, ovr_bytes[k], 1'b0}, 10);
      if (k == 3) checkOutput("ovr_not_yet", if_a.rx_overrun, 1'b0);
    end
    repeat (4) @(negedge clk);
    checkOutput("ovr_flag", if_a.rx_overrun, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("ovr_data%0d", k), if_a.r_data, ovr_bytes[k]);
      popRx(0);
    end
    checkOutput("ovr_only_four", if_a.rx_empty, 1'b1);
    clearErr(0);
    checkOutput("ovr_cleared", if_a.rx_overrun, 1'b0);

    // Odd parity on B: 0x07 has three ones, so the correct parity bit is 0.
    applyStimulus(1, {1'b1, 1'b1, 8'h07, 1'b0}, 11);
    repeat (4) @(negedge clk);
    checkOutput("par_bad_pushed", if_b.rx_empty, 1'b0);
    checkOutput("par_bad_data", if_b.r_data, 8'h07);
    checkOutput("par_bad_flag", if_b.rx_parity_err, 1'b1);
    popRx(1);
    clearErr(1);
    checkOutput("par_cleared", if_b.rx_parity_err, 1'b0);
    applyStimulus(1, {1'b1, 1'b0, 8'h07, 1'b0}, 11);
    repeat (4) @(negedge clk);
    checkOutput("par_good_data", if_b.r_data, 8'h07);
    checkOutput("par_good_flag", if_b.rx_parity_err, 1'b0);
    popRx(1);

    // B loopback: 0x03 has two ones, so the transmitter must send parity 1.
    loop_b = 1'b1;
    writeTx(1, 8'h03);
    waitRx(1, 2000);
    checkOutput("blb_ready", if_b.rx_empty, 1'b0);
    checkOutput("blb_data", if_b.r_data, 8'h03);
    checkOutput("blb_perr", if_b.rx_parity_err, 1'b0);
    checkOutput("blb_ferr", if_b.rx_frame_err, 1'b0);
    popRx(1);
    waitTxIdle(1, 500);
    loop_b = 1'b0;
    checkOutput("blb_tx_idle", tx_b, 1'b1);

    // Reset in the middle of a TX data bit with both FIFOs holding data.
    applyStimulus(0, {1'b1, 8'h5A, 1'b0}, 10);
    repeat (4) @(negedge clk);
    checkOutput("mr_rx_loaded", if_a.rx_empty, 1'b0);
    writeTx(0, 8'h00);
    writeTx(0, 8'h01);
    writeTx(0, 8'h02);
    writeTx(0, 8'h03);
    writeTx(0, 8'h04);
    checkOutput("mr_tx_full", if_a.tx_full, 1'b1);
    waitTxFall(0, 200);
    repeat (96) @(negedge clk);
    checkOutput("mr_in_data_low", tx_a, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mr_tx_high", tx_a, 1'b1);
    checkOutput("mr_full_clr", if_a.tx_full, 1'b0);
    checkOutput("mr_rx_empty", if_a.rx_empty, 1'b1);
    checkOutput("mr_busy_clr", if_a.tx_busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("mr_stays_idle", tx_a, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
